// File: rtl/crc_sig_checker.sv
// crc_sig_checker
//   On-board correctness checker placed after crc_gen_byteEn. It counts packet
//   ends on the generator's input side (flitEn & dlast), folds every CRC result
//   into a rotate-left-by-one / XOR signature, and gives one sticky verdict
//   once PKT_LIMIT results have been folded: PASS when the signature equals
//   EXP_SIG, FAIL otherwise. It also fails on a result with nothing
//   outstanding, on an excess packet end, and on a stalled generator (timeout).
//
//   Optional feature macro: CRC_CHK_LAT_EN
//     Adds a free-running 16-bit timestamp, a LAT_DEPTH-entry timestamp FIFO
//     and the lat_max / lat_min outputs (end-of-packet to result latency).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flitEn, dlast       input-side flit valid / last flit of a packet
//   crc_out, crc_out_vld generator result and its valid
//   busy                run in progress (RUN or DRAIN)
//   pass, fail          sticky verdict
//   err_code            first error: 1 extra result, 2 timeout, 3 signature
//                       mismatch, 4 excess packet end, 5 latency FIFO overflow
//   sig_out             running signature
//   pkt_in_cnt          packet ends counted
//   pkt_out_cnt         results counted
//   lat_max, lat_min    latency extremes (CRC_CHK_LAT_EN only)
module crc_sig_checker #(
    parameter int unsigned          CRC_WIDTH = 32,
    parameter logic [7:0]           PKT_LIMIT = 8'd100,
    parameter logic [CRC_WIDTH-1:0] EXP_SIG   = {CRC_WIDTH{1'b0}},
    parameter logic [CRC_WIDTH-1:0] SIG_INIT  = {CRC_WIDTH{1'b0}},
    parameter logic [15:0]          TIMEOUT   = 16'd1024,
    parameter int unsigned          LAT_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flitEn,
    input  logic                 dlast,
    input  logic [CRC_WIDTH-1:0] crc_out,
    input  logic                 crc_out_vld,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [2:0]           err_code,
    output logic [CRC_WIDTH-1:0] sig_out,
    output logic [7:0]           pkt_in_cnt,
    output logic [7:0]           pkt_out_cnt
`ifdef CRC_CHK_LAT_EN
    ,
    output logic [15:0]          lat_max,
    output logic [15:0]          lat_min
`endif
);

    // Elaboration-time parameter sanity.
    if (PKT_LIMIT == 8'd0) begin : g_bad_limit
        $error("crc_sig_checker: PKT_LIMIT must be in 1..255");
    end
    if (LAT_DEPTH < 2 || LAT_DEPTH > 256 || (LAT_DEPTH & (LAT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("crc_sig_checker: LAT_DEPTH must be a power of two in 2..256");
    end

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

    localparam logic [7:0] LAST_IN = PKT_LIMIT - 8'd1;

    state_t               state;
    logic [15:0]          tmo_cnt;
    logic                 ev_end, ev_res, running, active, pop, done, upd;
    logic [7:0]           outstanding;
    logic                 e1, e2, e3, e4, e5, any_err;
    logic [2:0]           err_nxt;
    logic [CRC_WIDTH-1:0] sig_rot;

    assign ev_end      = flitEn & dlast;
    assign ev_res      = crc_out_vld;
    // Registered counts only: this cycle's events are judged against the past.
    assign outstanding = pkt_in_cnt - pkt_out_cnt;
    assign running     = (state == S_RUN) || (state == S_DRAIN);
    // The IDLE cycle that starts the run is processed exactly like RUN.
    assign active      = running || ((state == S_IDLE) && (flitEn || crc_out_vld));
    assign pop         = active && ev_res && (outstanding != 8'd0);
    assign done        = (state == S_DRAIN) && (pkt_out_cnt == PKT_LIMIT);

    assign e1 = active && ev_res && (outstanding == 8'd0);
    assign e2 = running && (tmo_cnt == TIMEOUT);
    assign e3 = done && (sig_out != EXP_SIG);
    assign e4 = active && ev_end && (pkt_in_cnt == PKT_LIMIT);
`ifdef CRC_CHK_LAT_EN
    localparam logic [8:0] DEPTH9 = 9'(LAT_DEPTH);
    // FIFO occupancy always equals outstanding; a same-cycle pop frees a slot.
    assign e5 = active && ev_end && !pop && ({1'b0, outstanding} >= DEPTH9);
`else
    assign e5 = 1'b0;
`endif
    assign any_err = e1 | e2 | e3 | e4 | e5;
    // Counters, signature and FIFO move only on clean, non-final cycles, so
    // the cycle that fails leaves everything frozen at its previous value.
    assign upd     = active && !any_err && !done;

    always_comb begin
        err_nxt = 3'd0;
        if      (e1) err_nxt = 3'd1;
        else if (e2) err_nxt = 3'd2;
        else if (e3) err_nxt = 3'd3;
        else if (e4) err_nxt = 3'd4;
        else if (e5) err_nxt = 3'd5;
    end

    assign sig_rot = (sig_out << 1) | (sig_out >> (CRC_WIDTH - 1));

    assign busy = running;
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            err_code    <= 3'd0;
            sig_out     <= SIG_INIT;
            pkt_in_cnt  <= 8'd0;
            pkt_out_cnt <= 8'd0;
            tmo_cnt     <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_RUN, S_DRAIN: begin
                    if (any_err) begin
                        state    <= S_FAIL;
                        err_code <= err_nxt;
                    end else if (done) begin
                        state <= S_PASS;
                    end else if (active) begin
                        if (ev_end)
                            pkt_in_cnt <= pkt_in_cnt + 8'd1;
                        if (pop) begin
                            pkt_out_cnt <= pkt_out_cnt + 8'd1;
                            sig_out     <= sig_rot ^ crc_out;
                        end
                        tmo_cnt <= (ev_res || outstanding == 8'd0) ? 16'd0 : tmo_cnt + 16'd1;
                        if (ev_end && pkt_in_cnt == LAST_IN)
                            state <= S_DRAIN;
                        else if (state == S_IDLE)
                            state <= S_RUN;
                    end
                end
                S_PASS: begin
                    if (ev_res) begin
                        state    <= S_FAIL;
                        err_code <= 3'd1;
                    end else if (ev_end) begin
                        state    <= S_FAIL;
                        err_code <= 3'd4;
                    end
                end
                default: ;  // S_FAIL holds until reset
            endcase
        end
    end

`ifdef CRC_CHK_LAT_EN
    localparam int AW = $clog2(LAT_DEPTH);

    logic [15:0]   ts;
    logic [15:0]   ts_mem [LAT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [15:0]   lat_now;

    // Modulo-2^16 difference; valid as long as a packet waits < 65536 cycles.
    assign lat_now = ts - ts_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (upd && ev_end)
            ts_mem[wr_ptr] <= ts;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts      <= 16'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lat_max <= 16'h0000;
            lat_min <= 16'hFFFF;
        end else begin
            ts <= ts + 16'd1;
            if (upd && ev_end)
                wr_ptr <= wr_ptr + AW'(1);
            if (upd && pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (lat_now > lat_max) lat_max <= lat_now;
                if (lat_now < lat_min) lat_min <= lat_now;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc_sig_checker.sv
// Bench for crc_sig_checker. Four 8-bit instances share one stimulus bus:
//   0: PKT_LIMIT=2, EXP_SIG=00          1: PKT_LIMIT=2, EXP_SIG=5A
//   2: PKT_LIMIT=1, EXP_SIG=00          3: PKT_LIMIT=6, EXP_SIG=A5, SIG_INIT=3C
// all with TIMEOUT=16, LAT_DEPTH=4. Instance 3 is tracked by a reference
// model built from the verdict rules and driven with random traffic.
module tb_crc_sig_checker;

    logic       clk = 1'b0;
    logic       rst, flitEn, dlast, crc_out_vld;
    logic [7:0] crc_out;

    always #5 clk = ~clk;

    localparam logic [3:0][7:0] LIMS  = {8'd6, 8'd1, 8'd2, 8'd2};
    localparam logic [3:0][7:0] EXPS  = {8'hA5, 8'h00, 8'h5A, 8'h00};
    localparam logic [3:0][7:0] INITS = {8'h3C, 8'h00, 8'h00, 8'h00};
    localparam int LIM_R = 6;
    localparam int TMO_R = 16;
`ifdef CRC_CHK_LAT_EN
    localparam bit LAT_ON = 1'b1;
`else
    localparam bit LAT_ON = 1'b0;
`endif

    logic       busy_v [4], pass_v [4], fail_v [4];
    logic [2:0] err_v  [4];
    logic [7:0] sig_v  [4], in_v [4], out_v [4];
`ifdef CRC_CHK_LAT_EN
    logic [15:0] lmax_v [4], lmin_v [4];
`endif

    for (genvar g = 0; g < 4; g++) begin : g_dut
        crc_sig_checker #(
            .CRC_WIDTH (8),
            .PKT_LIMIT (LIMS[g]),
            .EXP_SIG   (EXPS[g]),
            .SIG_INIT  (INITS[g]),
            .TIMEOUT   (16'd16),
            .LAT_DEPTH (4)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .flitEn      (flitEn),
            .dlast       (dlast),
            .crc_out     (crc_out),
            .crc_out_vld (crc_out_vld),
            .busy        (busy_v[g]),
            .pass        (pass_v[g]),
            .fail        (fail_v[g]),
            .err_code    (err_v[g]),
            .sig_out     (sig_v[g]),
            .pkt_in_cnt  (in_v[g]),
            .pkt_out_cnt (out_v[g])
`ifdef CRC_CHK_LAT_EN
            ,
            .lat_max     (lmax_v[g]),
            .lat_min     (lmin_v[g])
`endif
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    // ---------------- reference model for instance 3 ----------------
    bit         m_started;
    int         m_verdict;   // 0 undecided, 1 pass, 2 fail
    int         m_err, m_in, m_out, m_tmo, m_ts, m_lmax, m_lmin;
    logic [7:0] m_sig;
    int         m_q[$];      // timestamps of packets awaiting a result

    task automatic model_upd();
        logic ev_end, ev_res;
        int   outst, code, p, lat;
        bit   drn;
        if (rst) begin
            m_started = 1'b0; m_verdict = 0; m_err = 0; m_in = 0; m_out = 0;
            m_sig = 8'h3C; m_tmo = 0; m_ts = 0; m_q.delete();
            m_lmax = 0; m_lmin = 16'hFFFF;
            return;
        end
        ev_end = flitEn & dlast;
        ev_res = crc_out_vld;
        if (m_verdict == 1) begin
            if (ev_res)      begin m_verdict = 2; m_err = 1; end
            else if (ev_end) begin m_verdict = 2; m_err = 4; end
        end else if (m_verdict == 0 && (m_started || flitEn || crc_out_vld)) begin
            m_started = 1'b1;
            outst = m_in - m_out;
            drn   = (m_in == LIM_R);
            code  = 0;
            if (ev_res && outst == 0)                                 code = 1;
            else if (m_tmo == TMO_R)                                  code = 2;
            else if (drn && m_out == LIM_R && m_sig != 8'hA5)         code = 3;
            else if (ev_end && m_in == LIM_R)                         code = 4;
            else if (LAT_ON && ev_end && m_q.size() >= 4 && !(ev_res && outst > 0)) code = 5;
            if (code != 0) begin
                m_verdict = 2; m_err = code;
            end else if (drn && m_out == LIM_R) begin
                m_verdict = 1;
            end else begin
                if (ev_res) begin
                    p   = m_q.pop_front();
                    lat = (m_ts - p) & 32'hFFFF;
                    if (lat > m_lmax) m_lmax = lat;
                    if (lat < m_lmin) m_lmin = lat;
                    m_out++;
                    m_sig = rotl8(m_sig) ^ crc_out;
                end
                if (ev_end) begin
                    m_in++;
                    m_q.push_back(m_ts);
                end
                m_tmo = (ev_res || outst == 0) ? 0 : m_tmo + 1;
            end
        end
        m_ts = (m_ts + 1) & 32'hFFFF;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic drive(input logic f, input logic d, input logic v, input logic [7:0] c);
        flitEn = f; dlast = d; crc_out_vld = v; crc_out = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".busy"}, 32'(busy_v[0]), 32'd0);
        chk({tag, ".pass"}, 32'(pass_v[0]), 32'd0);
        chk({tag, ".fail"}, 32'(fail_v[0]), 32'd0);
        chk({tag, ".err"},  32'(err_v[0]),  32'd0);
        chk({tag, ".sig"},  32'(sig_v[0]),  32'h00);
        chk({tag, ".in"},   32'(in_v[0]),   32'd0);
        chk({tag, ".out"},  32'(out_v[0]),  32'd0);
        chk({tag, ".sig_init"}, 32'(sig_v[3]), 32'h3C);
`ifdef CRC_CHK_LAT_EN
        chk({tag, ".lat_min"}, 32'(lmin_v[0]), 32'hFFFF);
        chk({tag, ".lat_max"}, 32'(lmax_v[0]), 32'h0);
`endif
    endtask

    // ---------------- directed vector table (instance 0) ----------------
    typedef struct {
        logic       f, d, v;
        logic [7:0] crc;
        logic [7:0] sig, in_c, out_c;
        logic       busy, pass, fail;
        logic [2:0] err;
    } vec_t;

    vec_t tbl[7];

    task automatic run_table(input string tag);
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].f, tbl[i].d, tbl[i].v, tbl[i].crc);
            step();
            chk($sformatf("%s[%0d].sig",  tag, i), 32'(sig_v[0]),  32'(tbl[i].sig));
            chk($sformatf("%s[%0d].in",   tag, i), 32'(in_v[0]),   32'(tbl[i].in_c));
            chk($sformatf("%s[%0d].out",  tag, i), 32'(out_v[0]),  32'(tbl[i].out_c));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy_v[0]), 32'(tbl[i].busy));
            chk($sformatf("%s[%0d].pass", tag, i), 32'(pass_v[0]), 32'(tbl[i].pass));
            chk($sformatf("%s[%0d].fail", tag, i), 32'(fail_v[0]), 32'(tbl[i].fail));
            chk($sformatf("%s[%0d].err",  tag, i), 32'(err_v[0]),  32'(tbl[i].err));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        //              f     d     v     crc     sig    in     out   busy  pass  fail  err
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'd1, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'd2, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'd2, 8'd1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 8'd2, 8'd2, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd2, 8'd2, 1'b0, 1'b1, 1'b0, 3'd0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        do_reset();
        chk_reset_state("reset");

        // Golden pass on instance 0; same stimulus mismatches on 1, overruns 2.
        run_table("pass_seq");
        chk("mismatch.fail", 32'(fail_v[1]), 32'd1);
        chk("mismatch.err",  32'(err_v[1]),  32'd3);
        chk("mismatch.out",  32'(out_v[1]),  32'd2);
        chk("mismatch.pass", 32'(pass_v[1]), 32'd0);
        chk("excess.fail",   32'(fail_v[2]), 32'd1);
        chk("excess.err",    32'(err_v[2]),  32'd4);
        chk("excess.in",     32'(in_v[2]),   32'd1);

        // Result after PASS turns it into FAIL(1); FAIL then ignores events.
        drive(1'b0, 1'b0, 1'b1, 8'h33);
        step();
        chk("post_pass.fail", 32'(fail_v[0]), 32'd1);
        chk("post_pass.err",  32'(err_v[0]),  32'd1);
        chk("post_pass.out",  32'(out_v[0]),  32'd2);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        chk("frozen.err", 32'(err_v[0]), 32'd1);
        chk("frozen.in",  32'(in_v[0]),  32'd2);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Result with nothing outstanding.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 8'h55);
        step();
        chk("extra.fail", 32'(fail_v[0]), 32'd1);
        chk("extra.err",  32'(err_v[0]),  32'd1);
        chk("extra.out",  32'(out_v[0]),  32'd0);

        // Packet end in the same cycle does not excuse the result.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 8'h55);
        step();
        chk("extra_same.fail", 32'(fail_v[0]), 32'd1);
        chk("extra_same.err",  32'(err_v[0]),  32'd1);
        chk("extra_same.out",  32'(out_v[0]),  32'd0);

        // Timeout: fail exactly 17 edges after the packet-end edge.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= 16; k++) step();
        chk("tmo.fail_at16", 32'(fail_v[0]), 32'd0);
        step();
        chk("tmo.fail_at17", 32'(fail_v[0]), 32'd1);
        chk("tmo.err",       32'(err_v[0]),  32'd2);

        // Reset in the middle of a run, with events on the reset cycle.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        step();
        chk_reset_state("midrst");
        rst = 1'b0;
        run_table("rerun");

`ifdef CRC_CHK_LAT_EN
        // Latencies 3 and 7 on instance 0.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00); step();     // E0
        drive(1'b1, 1'b1, 1'b0, 8'h00); step();     // E1
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();     // E2
        drive(1'b0, 1'b0, 1'b1, 8'h01); step();     // E3: 3 after E0
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) step();         // E4..E7
        drive(1'b0, 1'b0, 1'b1, 8'h02); step();     // E8: 7 after E1
        chk("lat.min", 32'(lmin_v[0]), 32'd3);
        chk("lat.max", 32'(lmax_v[0]), 32'd7);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        chk("lat.pass", 32'(pass_v[0]), 32'd1);
`endif

        // Five packet ends with no result on instance 3 (FIFO depth 4).
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) step();
        chk("ovf.fail_at4", 32'(fail_v[3]), 32'd0);
        step();
        chk("ovf.fail", 32'(fail_v[3]), LAT_ON ? 32'd1 : 32'd0);
        chk("ovf.err",  32'(err_v[3]),  LAT_ON ? 32'd5 : 32'd0);
        chk("ovf.in",   32'(in_v[3]),   LAT_ON ? 32'd4 : 32'd5);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic against the reference model.
        for (int r = 0; r < 40; r++) begin
            int mode, post, outst;
            logic f, d, v;
            logic [7:0] c;
            do_reset();
            mode = $urandom_range(0, 7);
            post = 0;
            for (int cyc = 0; cyc < 80 && post < 4; cyc++) begin
                outst = m_in - m_out;
                f = ($urandom_range(0, 1) == 1);
                d = ($urandom_range(0, 2) == 0);
                if (m_in == LIM_R && $urandom_range(0, 24) != 0) d = 1'b0;
                if (mode == 7)      v = 1'b0;
                else if (outst > 0) v = ($urandom_range(0, 9) < 4);
                else                v = ($urandom_range(0, 49) == 0);
                c = 8'($urandom);
                if (v && outst > 0 && m_out == LIM_R - 1 && $urandom_range(0, 1) == 1)
                    c = rotl8(m_sig) ^ 8'hA5;
                if (m_verdict != 0 && $urandom_range(0, 3) != 0) begin
                    f = 1'b0; v = 1'b0;
                end
                drive(f, d, v, c);
                step();
                chk($sformatf("rnd%0d.%0d.sig",  r, cyc), 32'(sig_v[3]),  32'(m_sig));
                chk($sformatf("rnd%0d.%0d.in",   r, cyc), 32'(in_v[3]),   32'(m_in));
                chk($sformatf("rnd%0d.%0d.out",  r, cyc), 32'(out_v[3]),  32'(m_out));
                chk($sformatf("rnd%0d.%0d.busy", r, cyc), 32'(busy_v[3]), 32'(m_started && m_verdict == 0));
                chk($sformatf("rnd%0d.%0d.pass", r, cyc), 32'(pass_v[3]), 32'(m_verdict == 1));
                chk($sformatf("rnd%0d.%0d.fail", r, cyc), 32'(fail_v[3]), 32'(m_verdict == 2));
                chk($sformatf("rnd%0d.%0d.err",  r, cyc), 32'(err_v[3]),  32'(m_err));
`ifdef CRC_CHK_LAT_EN
                chk($sformatf("rnd%0d.%0d.lmax", r, cyc), 32'(lmax_v[3]), 32'(m_lmax));
                chk($sformatf("rnd%0d.%0d.lmin", r, cyc), 32'(lmin_v[3]), 32'(m_lmin));
`endif
                if (m_verdict != 0) post++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
